// File: rtl/rv32i_pkg.sv
// Shared opcode/funct3 constants, immediate-format enum and the decoded control bundle.
// The csr field exists only when RV32I_DECODE_ZICSR_EN is defined.
package rv32i_pkg;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

  localparam logic [2:0] F3_SB = 3'd0;
  localparam logic [2:0] F3_SH = 3'd1;
  localparam logic [2:0] F3_SW = 3'd2;

  localparam logic [2:0] F3_BEQ  = 3'd0;
  localparam logic [2:0] F3_BNE  = 3'd1;
  localparam logic [2:0] F3_BLT  = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6;
  localparam logic [2:0] F3_BGEU = 3'd7;

  localparam logic [2:0] F3_SLL = 3'd1;
  localparam logic [2:0] F3_SRX = 3'd5;
  localparam logic [2:0] F3_ADD = 3'd0;
  localparam logic [2:0] F3_PRIV = 3'd0;

  typedef enum logic [2:0] {
    IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_Z, IMM_NONE
  } imm_fmt_t;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic branch;
    logic jal;
    logic jalr;
    logic lui;
    logic auipc;
    logic system;
    logic illegal;
`ifdef RV32I_DECODE_ZICSR_EN
    logic csr;
`endif
  } ctrl_t;

endpackage

// File: rtl/rv32i_imm_gen.sv
// Combinational immediate builder: selects and sign-extends the immediate field
// of a 32-bit RV32I instruction according to the decoded format.
module rv32i_imm_gen
  import rv32i_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned ILEN = 32
) (
  input  logic [ILEN-1:0] instruction_i,
  input  imm_fmt_t        fmt_i,
  output logic [XLEN-1:0] imm_o
);

  logic [31:0] i;
  logic [31:0] imm32;

  assign i = instruction_i[31:0];

  always_comb begin
    imm32 = '0;
    unique case (fmt_i)
      IMM_I:   imm32 = {{20{i[31]}}, i[31:20]};
      IMM_S:   imm32 = {{20{i[31]}}, i[31:25], i[11:7]};
      IMM_B:   imm32 = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      IMM_U:   imm32 = {i[31:12], 12'b0};
      IMM_J:   imm32 = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      IMM_Z:   imm32 = {27'b0, i[19:15]};
      default: imm32 = '0;
    endcase
  end

  assign imm_o = XLEN'($signed(imm32));

endmodule

// File: rtl/rv32i_decode.sv
// Decode stage: registers the decoded control bundle and owns load-use hazard
// detection (one bubble, stall_o back-pressures fetch). CSR decode under RV32I_DECODE_ZICSR_EN.
module rv32i_decode
  import rv32i_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned ILEN = 32
) (
  input  logic            clk_i,
  input  logic            reset_ni,
  input  logic            clear_i,
  input  logic            advance_i,
  input  logic            valid_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [ILEN-1:0] instruction_i,
  output logic            stall_o,
  output logic            valid_o,
  output logic [XLEN-1:0] pc_o,
  output logic [4:0]      rs1_o,
  output logic [4:0]      rs2_o,
  output logic [4:0]      rd_o,
  output logic [XLEN-1:0] imm_o,
  output logic [2:0]      funct3_o,
  output logic            alu_alt_o,
  output logic            reg_write_o,
  output logic            mem_read_o,
  output logic            mem_write_o,
  output logic            branch_o,
  output logic            jal_o,
  output logic            jalr_o,
  output logic            lui_o,
  output logic            auipc_o,
  output logic            system_o,
`ifdef RV32I_DECODE_ZICSR_EN
  output logic            csr_o,
  output logic [11:0]     csr_addr_o,
`endif
  output logic            illegal_o
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [4:0]      rs1, rs2, rd;
  ctrl_t           dec;
  ctrl_t           ctrl_q;
  imm_fmt_t        fmt;
  logic            legal, uses_rs1, uses_rs2, alt;
  logic [XLEN-1:0] imm;
  logic            ld_pending;
  logic [4:0]      ld_rd;

  assign opcode = instruction_i[6:0];
  assign funct3 = instruction_i[14:12];
  assign funct7 = instruction_i[31:25];
  assign rd     = instruction_i[11:7];
  assign rs1    = instruction_i[19:15];
  assign rs2    = instruction_i[24:20];

  always_comb begin
    dec      = '0;
    fmt      = IMM_NONE;
    legal    = 1'b0;
    uses_rs1 = 1'b1;
    uses_rs2 = 1'b0;
    alt      = 1'b0;
    unique case (opcode)
      OPC_LUI:   begin legal = 1'b1; dec.lui = 1'b1; dec.reg_write = 1'b1; fmt = IMM_U; uses_rs1 = 1'b0; end
      OPC_AUIPC: begin legal = 1'b1; dec.auipc = 1'b1; dec.reg_write = 1'b1; fmt = IMM_U; uses_rs1 = 1'b0; end
      OPC_JAL:   begin legal = 1'b1; dec.jal = 1'b1; dec.reg_write = 1'b1; fmt = IMM_J; uses_rs1 = 1'b0; end
      OPC_JALR: begin
        legal = (funct3 == F3_ADD);
        dec.jalr = 1'b1; dec.reg_write = 1'b1; fmt = IMM_I;
      end
      OPC_BRANCH: begin
        legal = (funct3 == F3_BEQ) || (funct3 == F3_BNE) || (funct3 == F3_BLT) ||
                (funct3 == F3_BGE) || (funct3 == F3_BLTU) || (funct3 == F3_BGEU);
        dec.branch = 1'b1; fmt = IMM_B; uses_rs2 = 1'b1;
      end
      OPC_LOAD: begin
        legal = (funct3 == F3_LB) || (funct3 == F3_LH) || (funct3 == F3_LW) ||
                (funct3 == F3_LBU) || (funct3 == F3_LHU);
        dec.mem_read = 1'b1; dec.reg_write = 1'b1; fmt = IMM_I;
      end
      OPC_STORE: begin
        legal = (funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW);
        dec.mem_write = 1'b1; fmt = IMM_S; uses_rs2 = 1'b1;
      end
      OPC_OP_IMM: begin
        dec.reg_write = 1'b1; fmt = IMM_I;
        if (funct3 == F3_SLL)      legal = (funct7 == 7'h00);
        else if (funct3 == F3_SRX) legal = (funct7 == 7'h00) || (funct7 == 7'h20);
        else                       legal = 1'b1;
        alt = ((funct3 == F3_SLL) || (funct3 == F3_SRX)) && instruction_i[30];
      end
      OPC_OP: begin
        dec.reg_write = 1'b1; uses_rs2 = 1'b1; alt = instruction_i[30];
        legal = (funct7 == 7'h00) ||
                ((funct7 == 7'h20) && ((funct3 == F3_ADD) || (funct3 == F3_SRX)));
      end
      OPC_MISC_MEM: begin legal = 1'b1; fmt = IMM_I; end
      OPC_SYSTEM: begin
        dec.system = 1'b1; fmt = IMM_I;
`ifdef RV32I_DECODE_ZICSR_EN
        if (funct3 == F3_PRIV) legal = 1'b1;
        else if (funct3 != 3'd4) begin
          legal = 1'b1; dec.csr = 1'b1; dec.reg_write = (rd != 5'd0); fmt = IMM_Z;
        end
`else
        legal = (funct3 == F3_PRIV);
`endif
      end
      default: legal = 1'b0;
    endcase
    if (instruction_i[1:0] != 2'b11) legal = 1'b0;
    // An illegal instruction still issues, but only as a trap marker.
    if (!legal) begin
      dec         = '0;
      dec.illegal = 1'b1;
    end
  end

  rv32i_imm_gen #(.XLEN(XLEN), .ILEN(ILEN)) u_imm_gen (
    .instruction_i (instruction_i),
    .fmt_i         (fmt),
    .imm_o         (imm)
  );

  assign stall_o = valid_i & ld_pending & !clear_i &
                   ((uses_rs1 & (rs1 == ld_rd)) | (uses_rs2 & (rs2 == ld_rd)));

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      valid_o    <= 1'b0;
      pc_o       <= '0;
      rs1_o      <= '0;
      rs2_o      <= '0;
      rd_o       <= '0;
      imm_o      <= '0;
      funct3_o   <= '0;
      alu_alt_o  <= 1'b0;
      ctrl_q     <= '0;
      ld_pending <= 1'b0;
      ld_rd      <= '0;
`ifdef RV32I_DECODE_ZICSR_EN
      csr_addr_o <= '0;
`endif
    end else if (clear_i) begin
      valid_o    <= 1'b0;
      ld_pending <= 1'b0;
    end else if (advance_i) begin
      if (stall_o) begin
        // Bubble: the held instruction is re-presented by fetch next cycle.
        valid_o    <= 1'b0;
        ctrl_q     <= '0;
        rd_o       <= '0;
        ld_pending <= 1'b0;
      end else begin
        valid_o    <= valid_i;
        pc_o       <= pc_i;
        rs1_o      <= rs1;
        rs2_o      <= rs2;
        rd_o       <= (valid_i && dec.reg_write) ? rd : 5'd0;
        imm_o      <= imm;
        funct3_o   <= funct3;
        alu_alt_o  <= alt;
        ctrl_q     <= valid_i ? dec : '0;
        ld_pending <= valid_i & dec.mem_read & (rd != 5'd0);
        ld_rd      <= rd;
`ifdef RV32I_DECODE_ZICSR_EN
        csr_addr_o <= instruction_i[31:20];
`endif
      end
    end
  end

  assign reg_write_o = ctrl_q.reg_write;
  assign mem_read_o  = ctrl_q.mem_read;
  assign mem_write_o = ctrl_q.mem_write;
  assign branch_o    = ctrl_q.branch;
  assign jal_o       = ctrl_q.jal;
  assign jalr_o      = ctrl_q.jalr;
  assign lui_o       = ctrl_q.lui;
  assign auipc_o     = ctrl_q.auipc;
  assign system_o    = ctrl_q.system;
  assign illegal_o   = ctrl_q.illegal;
`ifdef RV32I_DECODE_ZICSR_EN
  assign csr_o       = ctrl_q.csr;
`endif

endmodule

// File: tb/tb_rv32i_decode.sv
// Directed self-checking bench for rv32i_decode: decode formats, illegal
// encodings, load-use bubble, flush, hold and reset behaviour.
module tb_rv32i_decode;

  logic        clk_i = 1'b0;
  logic        reset_ni = 1'b0;
  logic        clear_i = 1'b0;
  logic        advance_i = 1'b0;
  logic        valid_i = 1'b0;
  logic [31:0] pc_i = '0;
  logic [31:0] instruction_i = '0;
  logic        stall_o, valid_o;
  logic [31:0] pc_o, imm_o;
  logic [4:0]  rs1_o, rs2_o, rd_o;
  logic [2:0]  funct3_o;
  logic        alu_alt_o, reg_write_o, mem_read_o, mem_write_o, branch_o;
  logic        jal_o, jalr_o, lui_o, auipc_o, system_o, illegal_o;
`ifdef RV32I_DECODE_ZICSR_EN
  logic        csr_o;
  logic [11:0] csr_addr_o;
`endif

  int n_chk = 0;
  int n_fail = 0;

  localparam logic [31:0] I_ADDI  = 32'hFFF00293; // addi x5,x0,-1
  localparam logic [31:0] I_LW    = 32'h0040A303; // lw x6,4(x1)
  localparam logic [31:0] I_ADD   = 32'h002303B3; // add x7,x6,x2
  localparam logic [31:0] I_LW0   = 32'h0000A003; // lw x0,0(x1)
  localparam logic [31:0] I_ADD0  = 32'h000003B3; // add x7,x0,x0
  localparam logic [31:0] I_BEQ   = 32'hFE208CE3; // beq x1,x2,-8
  localparam logic [31:0] I_SW    = 32'hFE20AE23; // sw x2,-4(x1)
  localparam logic [31:0] I_LUI   = 32'h123452B7; // lui x5,0x12345
  localparam logic [31:0] I_JAL   = 32'h008000EF; // jal x1,+8
  localparam logic [31:0] I_SUB   = 32'h402081B3; // sub x3,x1,x2
  localparam logic [31:0] I_BADOP = 32'h400013B3; // funct7 0x20 with funct3 1
  localparam logic [31:0] I_CSRRW = 32'h300110F3; // csrrw x1,0x300,x2

  rv32i_decode #(.XLEN(32), .ILEN(32)) dut (
    .clk_i(clk_i), .reset_ni(reset_ni), .clear_i(clear_i), .advance_i(advance_i),
    .valid_i(valid_i), .pc_i(pc_i), .instruction_i(instruction_i),
    .stall_o(stall_o), .valid_o(valid_o), .pc_o(pc_o),
    .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o), .imm_o(imm_o),
    .funct3_o(funct3_o), .alu_alt_o(alu_alt_o), .reg_write_o(reg_write_o),
    .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .branch_o(branch_o),
    .jal_o(jal_o), .jalr_o(jalr_o), .lui_o(lui_o), .auipc_o(auipc_o),
    .system_o(system_o),
`ifdef RV32I_DECODE_ZICSR_EN
    .csr_o(csr_o), .csr_addr_o(csr_addr_o),
`endif
    .illegal_o(illegal_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic drive(input logic [31:0] pc, input logic [31:0] ins);
    pc_i = pc; instruction_i = ins; valid_i = 1'b1; advance_i = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic test_reset();
    #12;
    n_chk++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0h want 0", valid_o); end
    n_chk++; if (pc_o !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %0h want 0", pc_o); end
    n_chk++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %0h want 0", stall_o); end
    n_chk++; if ({reg_write_o, mem_read_o, illegal_o, rd_o} !== 8'h0) begin n_fail++; $display("FAIL reset_flags got %0h want 0", {reg_write_o, mem_read_o, illegal_o, rd_o}); end
    tick(); reset_ni = 1'b1; #1;
  endtask

  task automatic test_addi();
    drive(32'h100, I_ADDI); tick();
    n_chk++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL addi_valid got %0h want 1", valid_o); end
    n_chk++; if (rd_o !== 5'd5) begin n_fail++; $display("FAIL addi_rd got %0d want 5", rd_o); end
    n_chk++; if (imm_o !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL addi_imm got %0h want ffffffff", imm_o); end
    n_chk++; if (reg_write_o !== 1'b1) begin n_fail++; $display("FAIL addi_regwrite got %0h want 1", reg_write_o); end
    n_chk++; if (pc_o !== 32'h100) begin n_fail++; $display("FAIL addi_pc got %0h want 100", pc_o); end
  endtask

  task automatic test_load_use();
    drive(32'h104, I_LW); tick();
    n_chk++; if (mem_read_o !== 1'b1) begin n_fail++; $display("FAIL lw_memread got %0h want 1", mem_read_o); end
    n_chk++; if ({rd_o, rs1_o} !== {5'd6, 5'd1}) begin n_fail++; $display("FAIL lw_regs got %0h want %0h", {rd_o, rs1_o}, {5'd6, 5'd1}); end
    n_chk++; if (imm_o !== 32'd4) begin n_fail++; $display("FAIL lw_imm got %0h want 4", imm_o); end
    drive(32'h108, I_ADD); #1;
    n_chk++; if (stall_o !== 1'b1) begin n_fail++; $display("FAIL lu_stall got %0h want 1", stall_o); end
    tick();
    n_chk++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL lu_bubble_valid got %0h want 0", valid_o); end
    n_chk++; if ({reg_write_o, mem_read_o} !== 2'b00) begin n_fail++; $display("FAIL lu_bubble_flags got %0h want 0", {reg_write_o, mem_read_o}); end
    n_chk++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL lu_stall_once got %0h want 0", stall_o); end
    tick();
    n_chk++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL lu_add_valid got %0h want 1", valid_o); end
    n_chk++; if ({rs1_o, rs2_o, rd_o} !== {5'd6, 5'd2, 5'd7}) begin n_fail++; $display("FAIL lu_add_regs got %0h want %0h", {rs1_o, rs2_o, rd_o}, {5'd6, 5'd2, 5'd7}); end
    n_chk++; if (pc_o !== 32'h108) begin n_fail++; $display("FAIL lu_add_pc got %0h want 108", pc_o); end
  endtask

  task automatic test_load_x0();
    drive(32'h200, I_LW0); tick();
    n_chk++; if (rd_o !== 5'd0) begin n_fail++; $display("FAIL lwx0_rd got %0d want 0", rd_o); end
    drive(32'h204, I_ADD0); #1;
    n_chk++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL lwx0_stall got %0h want 0", stall_o); end
    tick();
    n_chk++; if ({valid_o, rd_o} !== {1'b1, 5'd7}) begin n_fail++; $display("FAIL lwx0_add got %0h want %0h", {valid_o, rd_o}, {1'b1, 5'd7}); end
  endtask

  task automatic test_formats();
    drive(32'h300, I_BEQ); tick();
    n_chk++; if (branch_o !== 1'b1) begin n_fail++; $display("FAIL beq_branch got %0h want 1", branch_o); end
    n_chk++; if (imm_o !== 32'hFFFFFFF8) begin n_fail++; $display("FAIL beq_imm got %0h want fffffff8", imm_o); end
    n_chk++; if ({rd_o, reg_write_o} !== 6'h0) begin n_fail++; $display("FAIL beq_rd got %0h want 0", {rd_o, reg_write_o}); end
    drive(32'h304, I_SW); tick();
    n_chk++; if ({mem_write_o, rd_o} !== {1'b1, 5'd0}) begin n_fail++; $display("FAIL sw_flags got %0h want 20", {mem_write_o, rd_o}); end
    n_chk++; if (imm_o !== 32'hFFFFFFFC) begin n_fail++; $display("FAIL sw_imm got %0h want fffffffc", imm_o); end
    drive(32'h308, I_LUI); tick();
    n_chk++; if ({lui_o, rd_o} !== {1'b1, 5'd5}) begin n_fail++; $display("FAIL lui_flags got %0h want 25", {lui_o, rd_o}); end
    n_chk++; if (imm_o !== 32'h12345000) begin n_fail++; $display("FAIL lui_imm got %0h want 12345000", imm_o); end
    drive(32'h30C, I_JAL); tick();
    n_chk++; if ({jal_o, rd_o} !== {1'b1, 5'd1}) begin n_fail++; $display("FAIL jal_flags got %0h want 21", {jal_o, rd_o}); end
    n_chk++; if (imm_o !== 32'd8) begin n_fail++; $display("FAIL jal_imm got %0h want 8", imm_o); end
    drive(32'h310, I_SUB); tick();
    n_chk++; if ({alu_alt_o, illegal_o, imm_o} !== {2'b10, 32'h0}) begin n_fail++; $display("FAIL sub_alt got %0h want %0h", {alu_alt_o, illegal_o, imm_o}, {2'b10, 32'h0}); end
  endtask

  task automatic test_illegal();
    drive(32'h400, 32'h00000000); tick();
    n_chk++; if ({valid_o, illegal_o, reg_write_o, mem_read_o} !== 4'b1100) begin n_fail++; $display("FAIL ill_zero got %0h want c", {valid_o, illegal_o, reg_write_o, mem_read_o}); end
    drive(32'h404, 32'h0000702B); tick();
    n_chk++; if ({illegal_o, reg_write_o, mem_write_o, rd_o} !== {3'b100, 5'd0}) begin n_fail++; $display("FAIL ill_702b got %0h want 80", {illegal_o, reg_write_o, mem_write_o, rd_o}); end
    drive(32'h408, I_BADOP); tick();
    n_chk++; if ({illegal_o, reg_write_o} !== 2'b10) begin n_fail++; $display("FAIL ill_funct7 got %0h want 2", {illegal_o, reg_write_o}); end
    drive(32'h40C, I_CSRRW); tick();
`ifdef RV32I_DECODE_ZICSR_EN
    n_chk++; if ({csr_o, illegal_o, reg_write_o, rd_o} !== {3'b101, 5'd1}) begin n_fail++; $display("FAIL csr_flags got %0h want a1", {csr_o, illegal_o, reg_write_o, rd_o}); end
    n_chk++; if (csr_addr_o !== 12'h300) begin n_fail++; $display("FAIL csr_addr got %0h want 300", csr_addr_o); end
    n_chk++; if (imm_o !== 32'd2) begin n_fail++; $display("FAIL csr_imm got %0h want 2", imm_o); end
`else
    n_chk++; if ({illegal_o, system_o, reg_write_o} !== 3'b100) begin n_fail++; $display("FAIL csr_illegal got %0h want 4", {illegal_o, system_o, reg_write_o}); end
`endif
    drive(32'h410, I_ADDI); valid_i = 1'b0; tick();
    n_chk++; if ({valid_o, reg_write_o, rd_o} !== 7'h0) begin n_fail++; $display("FAIL novalid got %0h want 0", {valid_o, reg_write_o, rd_o}); end
  endtask

  task automatic test_clear_stall();
    drive(32'h500, I_LW); tick();
    drive(32'h504, I_ADD); #1;
    n_chk++; if (stall_o !== 1'b1) begin n_fail++; $display("FAIL clr_pre_stall got %0h want 1", stall_o); end
    clear_i = 1'b1; #1;
    n_chk++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL clr_stall got %0h want 0", stall_o); end
    tick();
    n_chk++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL clr_valid got %0h want 0", valid_o); end
    clear_i = 1'b0; #1;
    n_chk++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL clr_tracker got %0h want 0", stall_o); end
    tick();
    n_chk++; if ({valid_o, rd_o, rs1_o} !== {1'b1, 5'd7, 5'd6}) begin n_fail++; $display("FAIL clr_add got %0h want %0h", {valid_o, rd_o, rs1_o}, {1'b1, 5'd7, 5'd6}); end
  endtask

  task automatic test_hold();
    drive(32'h600, I_LUI); advance_i = 1'b0;
    repeat (3) tick();
    n_chk++; if ({valid_o, rd_o, reg_write_o, lui_o} !== {1'b1, 5'd7, 2'b10}) begin n_fail++; $display("FAIL hold_flags got %0h want %0h", {valid_o, rd_o, reg_write_o, lui_o}, {1'b1, 5'd7, 2'b10}); end
    n_chk++; if ({pc_o, imm_o} !== {32'h504, 32'h0}) begin n_fail++; $display("FAIL hold_pc_imm got %0h want %0h", {pc_o, imm_o}, {32'h504, 32'h0}); end
    advance_i = 1'b1; tick();
    n_chk++; if ({lui_o, rd_o, pc_o} !== {1'b1, 5'd5, 32'h600}) begin n_fail++; $display("FAIL hold_resume got %0h want %0h", {lui_o, rd_o, pc_o}, {1'b1, 5'd5, 32'h600}); end
  endtask

  task automatic test_reset_mid_stall();
    drive(32'h700, I_LW); tick();
    drive(32'h704, I_ADD); #1;
    n_chk++; if (stall_o !== 1'b1) begin n_fail++; $display("FAIL rst_pre_stall got %0h want 1", stall_o); end
    reset_ni = 1'b0; #1;
    n_chk++; if ({valid_o, stall_o, mem_read_o, rd_o, pc_o} !== 40'h0) begin n_fail++; $display("FAIL rst_mid got %0h want 0", {valid_o, stall_o, mem_read_o, rd_o, pc_o}); end
    reset_ni = 1'b1; #1;
    tick();
    n_chk++; if ({valid_o, rd_o, pc_o} !== {1'b1, 5'd7, 32'h704}) begin n_fail++; $display("FAIL rst_after got %0h want %0h", {valid_o, rd_o, pc_o}, {1'b1, 5'd7, 32'h704}); end
  endtask

  initial begin
    fork
      begin
        test_reset();
        test_addi();
        test_load_use();
        test_load_x0();
        test_formats();
        test_illegal();
        test_clear_stall();
        test_hold();
        test_reset_mid_stall();
      end
      begin
        #100000;
        n_chk++; n_fail++;
        $display("FAIL timeout got running want finished");
      end
    join_any
    disable fork;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
